// File: rtl/au_incdec_seq_if.sv
// Control/data bundle for the serial multi-word incrementer/decrementer.
interface au_incdec_seq_if #(
  parameter int W = 32
);
  logic         ld;
  logic [W-1:0] ld_data;
  logic         start;
  logic         inc_dec;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         co;

  modport master (
    output ld, ld_data, start, inc_dec, ci,
    input  busy, done, z, co
  );

  modport slave (
    input  ld, ld_data, start, inc_dec, ci,
    output busy, done, z, co
  );
endinterface

// File: rtl/au_incdec_seq.sv
// Wide operand register updated +/- ci one word per cycle through a shared
// prefix-AND incrementer; stops as soon as the carry/borrow dies.
module au_incdec_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4,
  parameter int ARCH  = 0
) (
  input  logic          clk,
  input  logic          rst,
  au_incdec_seq_if.slave bus
);
  localparam int W  = WIDTH * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  z_q, z_d;
  logic          co_q, co_d;
  logic [KW-1:0] k_q, k_d;
  logic          cr_q, cr_d;
  logic          op_q, op_d;

  logic [WIDTH-1:0] wrd_s, prop_s, pfx_s, res_s;
  logic             dp_co_s;

  // Shared datapath: inclusive prefix-AND of the propagate bits selects which bits flip.
  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    int               d;
    int               j;
    wrd_s  = z_q[int'(k_q)*WIDTH +: WIDTH];
    // Decrement is increment of the complemented word: a bit propagates a borrow when it is 0.
    prop_s = op_q ? ~wrd_s : wrd_s;
    cur    = prop_s;
    nxt    = prop_s;
    d      = 0;
    j      = 0;
    case (ARCH)
      1: begin
        for (int s = 0; s < LV; s++) begin
          d   = 1 << s;
          nxt = cur & ((cur << d) | ~({WIDTH{1'b1}} << d));
          cur = nxt;
        end
      end
      2: begin
        for (int s = 0; s < LV; s++) begin
          for (int i = 0; i < WIDTH; i++) begin
            j = (((i >> s) << s) > 0) ? (((i >> s) << s) - 1) : 0;
            if (((i >> s) & 1) == 1) begin
              nxt[i] = cur[i] & cur[j];
            end else begin
              nxt[i] = cur[i];
            end
          end
          cur = nxt;
        end
      end
      default: begin
        for (int i = 1; i < WIDTH; i++) begin
          cur[i] = cur[i-1] & prop_s[i];
        end
      end
    endcase
    pfx_s   = cur;
    res_s   = wrd_s ^ (((pfx_s << 1) | WIDTH'(1'b1)) & {WIDTH{cr_q}});
    dp_co_s = cr_q & pfx_s[WIDTH-1];
  end

  // Sequencer next-state: load/start acceptance and per-word RUN stepping.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    co_d    = co_q;
    k_d     = k_q;
    cr_d    = cr_q;
    op_d    = op_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.ld) begin
          z_d     = bus.ld_data;
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
          k_d     = {KW{1'b0}};
          cr_d    = bus.ci;
          op_d    = bus.inc_dec;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        z_d[int'(k_q)*WIDTH +: WIDTH] = res_s;
        cr_d = dp_co_s;
        k_d  = k_q + KW'(1);
        if (!dp_co_s || (k_q == K_LAST)) begin
          state_d = DONE;
          co_d    = dp_co_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      z_q     <= {W{1'b0}};
      co_q    <= 1'b0;
      k_q     <= {KW{1'b0}};
      cr_q    <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      co_q    <= co_d;
      k_q     <= k_d;
      cr_q    <= cr_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.z    = z_q;
  assign bus.co   = co_q;
endmodule

// File: doc/au_incdec_seq.md
Name: au_incdec_seq

Overview:
Multi-precision serial incrementer/decrementer controller. It holds a WORDS×WIDTH-bit operand register and sequences one shared WIDTH-bit incrementer-decrementer with carry-in/carry-out (a prefix-AND propagate datapath, ARCH-selectable) over the operand, least-significant word first. Carry is chained between words. The block stops early as soon as the carry dies. It is used where a wide counter or pointer must be updated without instantiating a full-width prefix tree.

Parameters:
WIDTH, 8, word length of the shared datapath (>= 1)
WORDS, 4, number of words in the operand (>= 2); total width W = WIDTH*WORDS
ARCH, 0, prefix-AND architecture passed to the datapath (0 to 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
ld  input  1  load operand register from ld_data (accepted only when busy=0)
ld_data  input  W  operand load value
start  input  1  begin one increment/decrement operation (accepted only when busy=0)
inc_dec  input  1  0: increment, 1: decrement; sampled with start
ci  input  1  carry-in (amount 0/1); sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse, operation complete
z  output  W  operand register contents
co  output  1  carry/borrow-out of the last completed operation

Behaviour:
- States: IDLE, RUN, DONE. Word index k: counter 0..WORDS-1, width clog2(WORDS), minimum 1 bit. Registered carry cr. Latched op bit op.
- Reset (async, any state): state=IDLE, z=0, co=0, busy=0, done=0, k=0, cr=0, op=0. Reset mid-RUN discards the partial result; z reads 0 immediately.
- busy = (state==RUN). done = (state==DONE). Both are registered-state decodes.
- ld and start are accepted in IDLE or DONE.
- ld has priority. If ld and start are both high in the same accepting cycle, the operand loads, start is dropped, and the state goes or stays IDLE.
- ld alone: next edge z<=ld_data. State goes or stays IDLE. co is unchanged.
- start alone: next edge state=RUN, k=0, cr<=ci, op<=inc_dec.
- ld, start, inc_dec and ci are ignored while busy=1.
- RUN, each cycle: the datapath gets word k of z, carry cr and op, all combinational. On the edge:
  - word k <= datapath result;
  - cr <= datapath carry-out;
  - k <= k+1.
- RUN exit, evaluated on the same edge: leave RUN if the datapath carry-out is 0 or k==WORDS-1. Next state is DONE, and co <= datapath carry-out. Words above k are untouched.
- Number of RUN cycles m = min(WORDS, index of first word whose carry-out is 0, plus 1).
- Latency: start sampled at edge E0; busy high for m cycles; done high for the single cycle after; then IDLE, unless a new start/ld is accepted in DONE.
- Datapath carry semantics:
  - increment: carry-out=1 iff word is all-ones and cr=1;
  - decrement: carry-out=1 iff word is all-zeros and cr=1 (borrow).
- ci=0: word 0 passes unchanged with carry-out 0. Result is m=1, z unchanged, co=0.
- Wrap-around: all-ones + 1 gives 0 with co=1. Zero - 1 gives all-ones with co=1. Both are modulo 2^W.
- co holds its value until the next operation completes. It is not cleared at start.
- done is never asserted together with busy.

Test Plan:
WIDTH=8, WORDS=4, every test run for ARCH=0,1,2.
- Early stop: ld 0x000000FF; start inc ci=1. Expect busy for 2 cycles, then done pulse 1 cycle; z=0x00000100, co=0.
- Full carry with wrap: ld 0xFFFFFFFF; start inc ci=1. Expect busy 4 cycles; z=0x00000000, co=1. Then ld 0x00000000; start dec ci=1. Expect busy 4 cycles; z=0xFFFFFFFF, co=1.
- Decrement borrow: ld 0x12340000; start dec ci=1. Expect busy 3 cycles; z=0x1233FFFF, co=0.
- ci=0, then back-to-back from DONE: ld 0x12345678; start inc ci=0. Expect busy 1 cycle; z=0x12345678, co=0 (co overwritten from a prior 1). Then start inc ci=1 in the done cycle. Expect accept; next busy=1; result 0x12345679.
- Ignored and priority controls: during RUN, pulse start, ld (data 0xAAAAAAAA) and flip inc_dec. Expect no effect on the result or cycle count. In IDLE, ld=1 with start=1 and data 0x00000005. Expect z=0x00000005, busy stays 0, no done.
- Async reset: ld 0xFFFFFFFF; start inc ci=1; assert rst mid-cycle while k=2. Expect z=0, co=0, busy=0, done=0 before the next clock edge. Expect no done after release; a subsequent op behaves normally.
